dcache_wb: RTL

- Parametrised successor to the first-generation direct-mapped data cache. Sits between the CPU load/store unit and the serial memory controller.
- Adds an explicit request/ack handshake with the core, and byte/half/word access for RV=16 or 32.
- Adds a write-back-then-refill state machine with configurable memory beat width, a whole-cache flush, and misalignment detection.

---
 rtl/dcache_wb.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back data cache between a load/store unit and a serial memory port
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req/write/size/paddr/wdata   core access request (held until ack or fault)
//   rdata/ack/fault              load data (zero unless ack), completion, misalignment pulse
//   flush/flush_done             write back every dirty line, one-cycle completion pulse
//   mreq/mwrite/maddr/mwdata     memory transfer request, direction, line address, write-back beat
//   mrdata/mstrobe               fill beat data, beat accepted this cycle
module dcache_wb #(
    parameter int RV = 16,
    parameter int PA = 22,
    parameter int LINE_LENGTH = 4,
    parameter int NLINES = 4,
    parameter int MW = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req,
    input  logic                            write,
    input  logic [1:0]                      size,
    input  logic [PA-1:0]                   paddr,
    input  logic [RV-1:0]                   wdata,
    output logic [RV-1:0]                   rdata,
    output logic                            ack,
    output logic                            fault,
    input  logic                            flush,
    output logic                            flush_done,
    output logic                            mreq,
    output logic                            mwrite,
    output logic [PA-$clog2(LINE_LENGTH)-1:0] maddr,
    output logic [MW-1:0]                   mwdata,
    input  logic [MW-1:0]                   mrdata,
    input  logic                            mstrobe
);
    localparam int OB = $clog2(LINE_LENGTH);
    localparam int IB = $clog2(NLINES);
    localparam int TB = PA - OB - IB;
    localparam int LW = LINE_LENGTH * 8;
    localparam int BEATS = LW / MW;
    localparam int BW = $clog2(BEATS);
    localparam logic [1:0] IDLE = 2'd0, WB = 2'd1, FILL = 2'd2, FSCAN = 2'd3;

    logic [1:0]        state;
    logic [BW-1:0]     beat;
    logic [IB-1:0]     widx;
    logic              flushing;
    logic [NLINES-1:0] valid, dirty;
    logic [TB-1:0]     tags [NLINES];
    logic [LW-1:0]     data [NLINES];

    logic [IB-1:0] index;
    logic [TB-1:0] tag;
    logic [OB-1:0] off;
    logic          hit, misalign, last_beat, last_idx;
    logic [RV-1:0] smask;
    logic [LW-1:0] cur, shifted, lmask, lwd, new_line, wline;

    always_comb begin
        index     = paddr[OB+IB-1:OB];
        tag       = paddr[PA-1:OB+IB];
        off       = paddr[OB-1:0];
        hit       = valid[index] && tags[index] == tag;
        misalign  = size == 2'd3 || (size == 2'd1 && paddr[0]) ||
                    (size == 2'd2 && (RV == 16 || paddr[1:0] != 2'd0));
        fault     = state == IDLE && req && misalign;
        ack       = state == IDLE && req && !misalign && hit;
        smask     = size == 2'd0 ? RV'(8'hFF) : size == 2'd1 ? RV'(16'hFFFF) : '1;
        cur       = data[index];
        shifted   = cur >> {off, 3'b000};
        rdata     = ack ? shifted[RV-1:0] & smask : '0;
        // store lanes: byte-enable mask and data both shifted into line position
        lmask     = LW'(smask) << {off, 3'b000};
        lwd       = LW'(wdata) << {off, 3'b000};
        new_line  = (cur & ~lmask) | (lwd & lmask);
        wline     = data[widx];
        mwdata    = wline[int'(beat)*MW +: MW];
        mreq      = state == WB || state == FILL;
        mwrite    = state == WB;
        maddr     = mwrite ? {tags[widx], widx} : {tag, index};
        last_beat = beat == BW'(BEATS - 1);
        last_idx  = widx == IB'(NLINES - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            beat       <= '0;
            widx       <= '0;
            flushing   <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ack && write) begin
                        dirty[index] <= 1'b1;
                    end else if (req && !misalign && !hit) begin
                        widx <= index;
                        if (valid[index] && dirty[index]) begin
                            state <= WB;
                        end else begin
                            state        <= FILL;
                            valid[index] <= 1'b0;
                        end
                    end else if (!req && flush) begin
                        state    <= FSCAN;
                        widx     <= '0;
                        flushing <= 1'b1;
                    end
                end
                WB: begin
                    if (mstrobe) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            beat        <= '0;
                            dirty[widx] <= 1'b0;
                            if (!flushing) begin
                                state        <= FILL;
                                valid[index] <= 1'b0;
                            end else if (last_idx) begin
                                state      <= IDLE;
                                flushing   <= 1'b0;
                                flush_done <= 1'b1;
                            end else begin
                                state <= FSCAN;
                                widx  <= widx + 1'b1;
                            end
                        end
                    end
                end
                FILL: begin
                    if (mstrobe) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            beat         <= '0;
                            valid[index] <= 1'b1;
                            dirty[index] <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                FSCAN: begin
                    if (valid[widx] && dirty[widx]) begin
                        state <= WB;
                    end else if (last_idx) begin
                        state      <= IDLE;
                        flushing   <= 1'b0;
                        flush_done <= 1'b1;
                    end else begin
                        widx <= widx + 1'b1;
                    end
                end
            endcase
        end
    end

    // line storage needs no reset: valid bits gate every use of it
    always_ff @(posedge clk) begin
        if (state == IDLE && ack && write)
            data[index] <= new_line;
        if (state == FILL && mstrobe)
            data[index][int'(beat)*MW +: MW] <= mrdata;
        if (state == FILL && mstrobe && last_beat)
            tags[index] <= tag;
    end
endmodule
